matmul_tile_scheduler: RTL and testbench
========================================

Name: matmul_tile_scheduler

Overview:
- Sequences the shared multiply_accumulate core array through a full matrix product C[R][N] = A[R][K] x B[K][N].
- Steps the array over output tiles of CORE_COUNT adjacent columns. Per tile: issues A/B read addresses, MAC clear/enable, drain, then a handshaked write-back strobe.
- Sits between a host start/done interface and the MAC array plus operand/result memories. Replaces free-running rst-pulse sequencing with explicit, stallable control.

Parameters:
- CORE_COUNT, 4, number of MAC cores; one output column per core per tile.
- DIM_W, 5, width of dimension and address fields; legal dims 0..2^DIM_W-1.
- MAC_LAT, 1, cycles from last mac_en to a valid acc on every core; range 1..7.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  level-sampled request; honoured only in IDLE
- cfg_rows  in  DIM_W  R
- cfg_inner  in  DIM_W  K
- cfg_cols  in  DIM_W  N
- busy  out  1  high in CLEAR, ACCUM, DRAIN, WRITE
- done  out  1  one-cycle completion pulse
- a_row  out  DIM_W  current output row; A row address
- a_col  out  DIM_W  inner index k; A column / B row address
- b_col_base  out  DIM_W  first output column of the tile; core i uses b_col_base+i
- mac_clr  out  1  clear all accumulators
- mac_en  out  1  accumulate current operands
- wb_valid  out  1  tile result valid
- wb_ready  in  1  result sink accepts
- wb_row  out  DIM_W  row of the tile being written
- wb_col_base  out  DIM_W  column base of the tile being written
- wb_mask  out  CORE_COUNT  bit i set when wb_col_base+i < N

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs 0. Internal row, k, col_base and config registers = 0. Reset mid-operation aborts immediately: no done pulse, no wb_valid.
- States: IDLE, CLEAR, ACCUM, DRAIN, WRITE, DONE. All outputs are registered decodes of state and counters.
- IDLE: on start=1, latch cfg_*.
  - If R, K or N = 0: go to DONE; no MAC or wb activity.
  - Otherwise: row=0, col_base=0, go to CLEAR.
- CLEAR (1 cycle): mac_clr=1, k=0, then go to ACCUM.
- ACCUM (K cycles): mac_en=1, a_col=k; k increments each cycle. After the cycle with k=K-1, go to DRAIN.
- DRAIN (MAC_LAT cycles): mac_en=0; a down-counter loaded with MAC_LAT-1; go to WRITE.
- WRITE:
  - Outputs: wb_valid=1; wb_row, wb_col_base, wb_mask held stable until wb_valid && wb_ready.
  - On acceptance, if col_base+CORE_COUNT >= N: col_base=0 and row++. Otherwise col_base += CORE_COUNT.
  - If the accepted tile was row R-1, last group: go to DONE. Otherwise go to CLEAR.
  - Internal sum is DIM_W+1 bits wide, so no wrap.
- DONE (1 cycle): done=1, busy=0, then go to IDLE.
- start is ignored outside IDLE; cfg_* changes during busy have no effect.
- Back-to-back: start held high re-launches from IDLE the cycle after DONE.
- Tiles per job: R x ceil(N/CORE_COUNT).
- Cycles per tile with wb_ready=1: 1+K+MAC_LAT+1.
- a_row always equals the row of the tile in progress; a_col is held at K-1 during DRAIN/WRITE.

Decomposition:
- Shared package matmul_pkg: state encoding constants (IDLE=0..DONE=5, 3-bit), CORE_COUNT default, DIM_W default.
- Sub-module matmul_tile_counter: row/col_base advance, last-tile detect, wb_mask generation. Keeps the FSM purely control.

Test Plan:
- R=K=N=6, CORE_COUNT=4, MAC_LAT=1, wb_ready=1 -> 12 tiles of 9 cycles. busy high 108 cycles, then done pulse. wb_mask alternates 4'b1111/4'b0011. Final wb_row=5, wb_col_base=4. C matches the golden product.
- R=2, K=3, N=4, wb_ready low for 5 cycles in the first WRITE -> wb_valid/wb_row=0/wb_col_base=0 stable for 6 cycles. No mac_clr until acceptance. Total busy = 2*(1+3+1+1)+5 = 17.
- cfg_inner=0 with start -> DONE the next cycle, done=1 for exactly 1 cycle. mac_clr, mac_en and wb_valid never assert; busy never asserts.
- start pulsed during ACCUM of a 3x3x3 job -> ignored. Exactly 3 wb transfers, one done pulse.
- rst asserted mid-ACCUM (k=2) -> all outputs 0 asynchronously, state IDLE. A new start runs a full job correctly from row 0.
- MAC_LAT=3, N=5, CORE_COUNT=4 -> 3 idle DRAIN cycles per tile, wb_mask 4'b1111 then 4'b0001.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply tile scheduler: defaults and FSM state encoding.
package matmul_pkg;

  localparam int CORE_COUNT_DEF = 4;
  localparam int DIM_W_DEF      = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ACCUM = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/matmul_tile_counter.sv
// Output-tile position tracker: row / column-base advance, last-tile detect and write-back mask.
module matmul_tile_counter
  import matmul_pkg::*;
#(
  parameter int CORE_COUNT = CORE_COUNT_DEF,
  parameter int DIM_W      = DIM_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic                  advance,
  input  logic [DIM_W-1:0]      rows,
  input  logic [DIM_W-1:0]      cols,
  output logic [DIM_W-1:0]      row_nxt,
  output logic [DIM_W-1:0]      col_nxt,
  output logic [CORE_COUNT-1:0] mask_nxt,
  output logic                  last_tile
);

  localparam int SUM_W = DIM_W + 1;

  logic [DIM_W-1:0] row_r;
  logic [DIM_W-1:0] col_r;
  logic [SUM_W-1:0] col_sum_s;
  logic             wrap_s;

  // Next tile position; the column sum is one bit wider so it never wraps.
  always_comb begin
    col_sum_s = {1'b0, col_r} + SUM_W'(CORE_COUNT);
    wrap_s    = (col_sum_s >= {1'b0, cols});
    last_tile = wrap_s && (row_r == (rows - DIM_W'(1)));
    row_nxt   = row_r;
    col_nxt   = col_r;
    mask_nxt  = '0;
    if (init) begin
      row_nxt = '0;
      col_nxt = '0;
    end else if (advance) begin
      if (wrap_s) begin
        row_nxt = row_r + DIM_W'(1);
        col_nxt = '0;
      end else begin
        row_nxt = row_r;
        col_nxt = col_sum_s[DIM_W-1:0];
      end
    end else begin
      row_nxt = row_r;
      col_nxt = col_r;
    end
    for (int i = 0; i < CORE_COUNT; i++) begin
      mask_nxt[i] = (({1'b0, col_nxt} + SUM_W'(i)) < {1'b0, cols});
    end
  end

  // Position registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_r <= '0;
      col_r <= '0;
    end else begin
      row_r <= row_nxt;
      col_r <= col_nxt;
    end
  end

endmodule

// File: rtl/matmul_tile_scheduler.sv
// Stallable sequencer stepping the MAC array over output tiles of C = A x B with handshaked write-back.
module matmul_tile_scheduler
  import matmul_pkg::*;
#(
  parameter int CORE_COUNT = CORE_COUNT_DEF,
  parameter int DIM_W      = DIM_W_DEF,
  parameter int MAC_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIM_W-1:0]      cfg_rows,
  input  logic [DIM_W-1:0]      cfg_inner,
  input  logic [DIM_W-1:0]      cfg_cols,
  output logic                  busy,
  output logic                  done,
  output logic [DIM_W-1:0]      a_row,
  output logic [DIM_W-1:0]      a_col,
  output logic [DIM_W-1:0]      b_col_base,
  output logic                  mac_clr,
  output logic                  mac_en,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [DIM_W-1:0]      wb_row,
  output logic [DIM_W-1:0]      wb_col_base,
  output logic [CORE_COUNT-1:0] wb_mask
);

  state_t                state_r, state_nxt_s;
  logic [DIM_W-1:0]      rows_r, inner_r, cols_r;
  logic [DIM_W-1:0]      k_r, k_nxt_s;
  logic [2:0]            drain_r, drain_nxt_s;
  logic                  load_cfg_s, tile_init_s, tile_adv_s, busy_nxt_s;
  logic [DIM_W-1:0]      row_nxt_s, col_nxt_s;
  logic [CORE_COUNT-1:0] mask_nxt_s;
  logic                  last_tile_s;

  matmul_tile_counter #(
    .CORE_COUNT (CORE_COUNT),
    .DIM_W      (DIM_W)
  ) u_tile_counter (
    .clk       (clk),
    .rst       (rst),
    .init      (tile_init_s),
    .advance   (tile_adv_s),
    .rows      (rows_r),
    .cols      (cols_r),
    .row_nxt   (row_nxt_s),
    .col_nxt   (col_nxt_s),
    .mask_nxt  (mask_nxt_s),
    .last_tile (last_tile_s)
  );

  // Next-state, inner-index and drain-counter logic.
  always_comb begin
    state_nxt_s = state_r;
    k_nxt_s     = k_r;
    drain_nxt_s = drain_r;
    load_cfg_s  = 1'b0;
    tile_init_s = 1'b0;
    tile_adv_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          load_cfg_s = 1'b1;
          if ((cfg_rows == '0) || (cfg_inner == '0) || (cfg_cols == '0)) begin
            state_nxt_s = ST_DONE;
          end else begin
            tile_init_s = 1'b1;
            state_nxt_s = ST_CLEAR;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        k_nxt_s     = '0;
        state_nxt_s = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (k_r == (inner_r - DIM_W'(1))) begin
          drain_nxt_s = 3'(MAC_LAT - 1);
          state_nxt_s = ST_DRAIN;
        end else begin
          k_nxt_s = k_r + DIM_W'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_r == 3'd0) begin
          state_nxt_s = ST_WRITE;
        end else begin
          drain_nxt_s = drain_r - 3'd1;
        end
      end
      ST_WRITE: begin
        if (wb_ready) begin
          tile_adv_s  = 1'b1;
          state_nxt_s = last_tile_s ? ST_DONE : ST_CLEAR;
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
    busy_nxt_s = (state_nxt_s == ST_CLEAR) || (state_nxt_s == ST_ACCUM) ||
                 (state_nxt_s == ST_DRAIN) || (state_nxt_s == ST_WRITE);
  end

  // State, counters and latched job configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      k_r     <= '0;
      drain_r <= 3'd0;
      rows_r  <= '0;
      inner_r <= '0;
      cols_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      k_r     <= k_nxt_s;
      drain_r <= drain_nxt_s;
      if (load_cfg_s) begin
        rows_r  <= cfg_rows;
        inner_r <= cfg_inner;
        cols_r  <= cfg_cols;
      end
    end
  end

  // Outputs are decoded from next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      mac_clr     <= 1'b0;
      mac_en      <= 1'b0;
      wb_valid    <= 1'b0;
      a_row       <= '0;
      a_col       <= '0;
      b_col_base  <= '0;
      wb_row      <= '0;
      wb_col_base <= '0;
      wb_mask     <= '0;
    end else begin
      busy        <= busy_nxt_s;
      done        <= (state_nxt_s == ST_DONE);
      mac_clr     <= (state_nxt_s == ST_CLEAR);
      mac_en      <= (state_nxt_s == ST_ACCUM);
      wb_valid    <= (state_nxt_s == ST_WRITE);
      a_row       <= busy_nxt_s ? row_nxt_s : '0;
      a_col       <= busy_nxt_s ? k_nxt_s : '0;
      b_col_base  <= busy_nxt_s ? col_nxt_s : '0;
      wb_row      <= (state_nxt_s == ST_WRITE) ? row_nxt_s : '0;
      wb_col_base <= (state_nxt_s == ST_WRITE) ? col_nxt_s : '0;
      wb_mask     <= (state_nxt_s == ST_WRITE) ? mask_nxt_s : '0;
    end
  end

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Self-checking bench: a MAC-array/memory model driven by the scheduler, compared with a golden product and tile list.
module tb_matmul_tile_scheduler;

  localparam int CC = 4;
  localparam int DW = 5;

  typedef struct {
    int          row;
    int          cb;
    logic [CC-1:0] mask;
  } tile_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [1:0]    start_v;
  logic [DW-1:0] cfg_rows, cfg_inner, cfg_cols;
  logic          wb_ready;
  logic [1:0]    busy_v, done_v, mac_clr_v, mac_en_v, wb_valid_v;
  logic [DW-1:0] a_row_v [2];
  logic [DW-1:0] a_col_v [2];
  logic [DW-1:0] b_col_v [2];
  logic [DW-1:0] wb_row_v [2];
  logic [DW-1:0] wb_col_v [2];
  logic [CC-1:0] wb_mask_v [2];

  matmul_tile_scheduler #(.CORE_COUNT(CC), .DIM_W(DW), .MAC_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .start(start_v[0]),
    .cfg_rows(cfg_rows), .cfg_inner(cfg_inner), .cfg_cols(cfg_cols),
    .busy(busy_v[0]), .done(done_v[0]), .a_row(a_row_v[0]), .a_col(a_col_v[0]),
    .b_col_base(b_col_v[0]), .mac_clr(mac_clr_v[0]), .mac_en(mac_en_v[0]),
    .wb_valid(wb_valid_v[0]), .wb_ready(wb_ready), .wb_row(wb_row_v[0]),
    .wb_col_base(wb_col_v[0]), .wb_mask(wb_mask_v[0])
  );

  matmul_tile_scheduler #(.CORE_COUNT(CC), .DIM_W(DW), .MAC_LAT(3)) u_dut_lat3 (
    .clk(clk), .rst(rst), .start(start_v[1]),
    .cfg_rows(cfg_rows), .cfg_inner(cfg_inner), .cfg_cols(cfg_cols),
    .busy(busy_v[1]), .done(done_v[1]), .a_row(a_row_v[1]), .a_col(a_col_v[1]),
    .b_col_base(b_col_v[1]), .mac_clr(mac_clr_v[1]), .mac_en(mac_en_v[1]),
    .wb_valid(wb_valid_v[1]), .wb_ready(wb_ready), .wb_row(wb_row_v[1]),
    .wb_col_base(wb_col_v[1]), .wb_mask(wb_mask_v[1])
  );

  int checks = 0;
  int failures = 0;

  int A [0:31][0:31];
  int B [0:31][0:35];
  int C [0:31][0:35];
  int acc [CC];
  tile_t exp_q [$];

  int   sel = 0;
  bit   mon_en = 1'b0;
  int   busy_cnt, done_cnt, clr_cnt, en_cnt, wb_cnt, valid_cnt, stall_cnt, k_exp;
  bit   pend;
  logic [DW+DW+CC-1:0] prev_wb;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs(input int s);
    return {30'd0, busy_v[s], done_v[s], mac_clr_v[s], mac_en_v[s], wb_valid_v[s],
            a_row_v[s], a_col_v[s], b_col_v[s], wb_row_v[s], wb_col_v[s], wb_mask_v[s]};
  endfunction

  // MAC array, result memory and write-back observer, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy_v[sel]) busy_cnt++;
      if (done_v[sel]) done_cnt++;
      if (mac_clr_v[sel]) begin
        clr_cnt++;
        k_exp = 0;
        for (int i = 0; i < CC; i++) acc[i] = 0;
      end
      if (mac_en_v[sel]) begin
        en_cnt++;
        chk("a_col_seq", 64'(a_col_v[sel]), 64'(k_exp));
        k_exp++;
        for (int i = 0; i < CC; i++)
          acc[i] += A[a_row_v[sel]][a_col_v[sel]] * B[a_col_v[sel]][int'(b_col_v[sel]) + i];
      end
      if (pend)
        chk("wb_hold", {wb_valid_v[sel], wb_row_v[sel], wb_col_v[sel], wb_mask_v[sel]}, {1'b1, prev_wb});
      if (wb_valid_v[sel]) begin
        valid_cnt++;
        if (wb_ready) begin
          pend = 1'b0;
          wb_cnt++;
          if (exp_q.size() == 0) begin
            chk("wb_extra", 64'd1, 64'd0);
          end else begin
            tile_t t;
            t = exp_q.pop_front();
            chk("wb_row", 64'(wb_row_v[sel]), 64'(t.row));
            chk("wb_col_base", 64'(wb_col_v[sel]), 64'(t.cb));
            chk("wb_mask", 64'(wb_mask_v[sel]), 64'(t.mask));
          end
          for (int i = 0; i < CC; i++)
            if (wb_mask_v[sel][i]) C[wb_row_v[sel]][int'(wb_col_v[sel]) + i] = acc[i];
        end else begin
          pend = 1'b1;
          stall_cnt++;
          prev_wb = {wb_row_v[sel], wb_col_v[sel], wb_mask_v[sel]};
        end
      end else begin
        pend = 1'b0;
      end
    end
  end

  // One complete job on DUT s; mode 0 ready always, 1 stall first 5 valid cycles, 2 random ready.
  task automatic run_job(input int s, input int r, input int k, input int n, input int mode, input bit poke);
    int lat, tiles, cyc, stall_left, bad;
    bit poked;
    lat = (s == 1) ? 3 : 1;
    exp_q.delete();
    if (r > 0 && k > 0 && n > 0) begin
      for (int row = 0; row < r; row++)
        for (int cb = 0; cb < n; cb += CC) begin
          tile_t t;
          t.row = row;
          t.cb = cb;
          for (int i = 0; i < CC; i++) t.mask[i] = ((cb + i) < n);
          exp_q.push_back(t);
        end
    end
    tiles = exp_q.size();
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 36; j++) begin
        if (j < 32) A[i][j] = int'($urandom_range(15));
        B[i][j] = int'($urandom_range(15));
        C[i][j] = -1;
      end
    busy_cnt = 0; done_cnt = 0; clr_cnt = 0; en_cnt = 0; wb_cnt = 0;
    valid_cnt = 0; stall_cnt = 0; k_exp = 0; pend = 1'b0;
    sel = s;
    mon_en = 1'b1;
    wb_ready = 1'b1;
    cfg_rows = DW'(r); cfg_inner = DW'(k); cfg_cols = DW'(n);
    start_v[s] = 1'b1;
    @(posedge clk); #1;
    start_v[s] = 1'b0;
    cfg_rows = DW'($urandom); cfg_inner = DW'($urandom); cfg_cols = DW'($urandom);
    if (tiles == 0) chk("zero_done_next", {62'd0, done_v[s], busy_v[s]}, 64'd2);
    stall_left = (mode == 1) ? 5 : 0;
    poked = 1'b0;
    cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      start_v[s] = 1'b0;
      if (poke && !poked && mac_en_v[s]) begin
        start_v[s] = 1'b1;
        poked = 1'b1;
      end
      if (mode == 1 && wb_valid_v[s] && stall_left > 0) begin
        wb_ready = 1'b0;
        stall_left--;
      end else if (mode == 2) begin
        wb_ready = ($urandom_range(3) != 0);
      end else begin
        wb_ready = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start_v[s] = 1'b0;
    wb_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mon_en = 1'b0;
    chk("job_timeout", 64'(cyc < 3000), 64'd1);
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("busy_cycles", 64'(busy_cnt), 64'(tiles * (2 + k + lat) + stall_cnt));
    chk("wb_transfers", 64'(wb_cnt), 64'(tiles));
    chk("valid_cycles", 64'(valid_cnt), 64'(tiles + stall_cnt));
    chk("mac_clr_count", 64'(clr_cnt), 64'(tiles));
    chk("mac_en_count", 64'(en_cnt), 64'(tiles * k));
    if (mode == 1) chk("stall_cycles", 64'(stall_cnt), 64'd5);
    bad = 0;
    for (int i = 0; i < r; i++)
      for (int j = 0; j < n; j++) begin
        int sum;
        sum = 0;
        for (int kk = 0; kk < k; kk++) sum += A[i][kk] * B[kk][j];
        if (tiles > 0 && C[i][j] != sum) bad++;
      end
    chk("product_entries_wrong", 64'(bad), 64'd0);
  endtask

  initial begin
    int c;
    rst = 1'b1;
    start_v = 2'b00;
    wb_ready = 1'b1;
    cfg_rows = '0; cfg_inner = '0; cfg_cols = '0;
    #12;
    chk("reset_outs_lat1", outs(0), 64'd0);
    chk("reset_outs_lat3", outs(1), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run_job(0, 6, 6, 6, 0, 1'b0);
    run_job(0, 2, 3, 4, 1, 1'b0);
    run_job(0, 4, 0, 4, 0, 1'b0);
    run_job(0, 3, 3, 3, 0, 1'b1);
    run_job(0, 1, 2, 8, 0, 1'b0);

    // Asynchronous reset in the middle of accumulation.
    cfg_rows = 5'd3; cfg_inner = 5'd5; cfg_cols = 5'd7;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    c = 0;
    while (!(mac_en_v[0] && a_col_v[0] == 5'd2) && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    chk("reach_k2", 64'(c < 50), 64'd1);
    #2 rst = 1'b1;
    #1 chk("async_reset_outs", outs(0), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_reset", outs(0), 64'd0);
    run_job(0, 3, 5, 7, 0, 1'b0);

    run_job(1, 2, 4, 5, 0, 1'b0);

    for (int it = 0; it < 5; it++)
      run_job(int'($urandom_range(1)), int'($urandom_range(7, 1)), int'($urandom_range(6, 1)),
              int'($urandom_range(13, 1)), 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
